// File: rtl/hs32_mem_arbiter_pkg.sv
// Shared types for the HS32 memory arbiter: FSM states, port ids, slot payload
// and the grant-selection helper.
package hs32_mem_arbiter_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        P_FETCH = 1'b0,
        P_EXEC  = 1'b1
    } port_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dtw;
        logic        rw;
    } slot_req_t;

    // Execute port wins unless fetch is waiting and has been starved long enough.
    function automatic port_e pick_port(input logic [NUM_PORTS-1:0] cand, input logic starve_hit);
        if (cand[P_EXEC] && !(cand[P_FETCH] && starve_hit))
            return P_EXEC;
        return P_FETCH;
    endfunction

endpackage

// File: rtl/hs32_mem_arbiter_if.sv
// HS32 strobe/ack/stall bus for both initiator ports plus the backend memory
// request/ready bus, as seen by the arbiter (slave) and its environment (master).
interface hs32_mem_arbiter_if;
    logic [31:0] addr0;
    logic        stb0;
    logic [31:0] dtr0;
    logic        ack0;
    logic        stl0;

    logic [31:0] addr1;
    logic [31:0] dtw1;
    logic        rw1;
    logic        stb1;
    logic [31:0] dtr1;
    logic        ack1;
    logic        stl1;

    logic [31:0] maddr;
    logic [31:0] mdtw;
    logic        mwe;
    logic        mreq;
    logic [31:0] mdtr;
    logic        mrdy;

    modport slave (
        input  addr0, stb0, addr1, dtw1, rw1, stb1, mdtr, mrdy,
        output dtr0, ack0, stl0, dtr1, ack1, stl1, maddr, mdtw, mwe, mreq
    );

    modport master (
        output addr0, stb0, addr1, dtw1, rw1, stb1, mdtr, mrdy,
        input  dtr0, ack0, stl0, dtr1, ack1, stl1, maddr, mdtw, mwe, mreq
    );
endinterface

// File: rtl/hs32_arb_slot.sv
// One-deep request latch for a single initiator port. Flags misaligned or
// overlapping strobes and presents either the held or the just-arriving request.
module hs32_arb_slot
    import hs32_mem_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      stb,
    input  slot_req_t req_in,
    input  logic      clr,
    output logic      pend,
    output logic      err,
    output slot_req_t req
);
    logic      full;
    logic      busy;
    logic      cap;
    slot_req_t held;

    // A slot being released on this edge is free for a new strobe.
    assign busy = full && !clr;
    assign err  = stb && ((req_in.addr[1:0] != 2'b00) || busy);
    assign cap  = stb && !err;
    assign pend = cap || busy;
    assign req  = cap ? req_in : held;

    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= 1'b0;
            held <= '0;
        end else if (cap) begin
            full <= 1'b1;
            held <= req_in;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/hs32_mem_arbiter.sv
// Two-port HS32 responder: serialises fetch/execute accesses onto one backend
// bus with execute priority, fetch anti-starvation and a backend timeout.
module hs32_mem_arbiter
    import hs32_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    hs32_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e state;
    port_e      owner;
    logic [CW-1:0] cyc_cnt;
    logic [SW-1:0] starve_cnt;

    logic [NUM_PORTS-1:0] stb, pend, err, clr, cand;
    slot_req_t req_in [NUM_PORTS];
    slot_req_t req    [NUM_PORTS];

    logic  in_wait, done, tmo, grant_vld, starve_hit;
    port_e grant_port;

    assign stb             = {bus.stb1, bus.stb0};
    assign req_in[P_FETCH] = '{addr: bus.addr0, dtw: 32'h0, rw: 1'b0};
    assign req_in[P_EXEC]  = '{addr: bus.addr1, dtw: bus.dtw1, rw: bus.rw1};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        hs32_arb_slot u_slot (
            .clk    (clk),
            .reset  (reset),
            .stb    (stb[i]),
            .req_in (req_in[i]),
            .clr    (clr[i]),
            .pend   (pend[i]),
            .err    (err[i]),
            .req    (req[i])
        );
    end

    assign in_wait = (state == ST_WAIT);
    assign done    = in_wait && bus.mrdy;
    assign tmo     = in_wait && !bus.mrdy && (cyc_cnt == CW'(TIMEOUT - 1));

    assign clr[P_FETCH] = (done || tmo) && (owner == P_FETCH);
    assign clr[P_EXEC]  = (done || tmo) && (owner == P_EXEC);

    // Grants happen from IDLE or on a completing edge (back-to-back); never after a timeout.
    always_comb begin
        cand = '0;
        if (!in_wait || done)
            cand = pend;
    end

    assign starve_hit = (starve_cnt >= SW'(STARVE_LIMIT));
    assign grant_vld  = |cand;
    assign grant_port = pick_port(cand, starve_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= P_FETCH;
            cyc_cnt    <= '0;
            starve_cnt <= '0;
            bus.maddr  <= '0;
            bus.mdtw   <= '0;
            bus.mwe    <= 1'b0;
            bus.mreq   <= 1'b0;
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.stl0   <= 1'b0;
            bus.stl1   <= 1'b0;
            bus.dtr0   <= '0;
            bus.dtr1   <= '0;
        end else begin
            bus.ack0 <= done && (owner == P_FETCH);
            bus.ack1 <= done && (owner == P_EXEC);
            bus.stl0 <= err[P_FETCH] || (tmo && (owner == P_FETCH));
            bus.stl1 <= err[P_EXEC]  || (tmo && (owner == P_EXEC));

            // mwe still reflects the access that is completing.
            if (done) begin
                if (owner == P_FETCH)
                    bus.dtr0 <= bus.mdtr;
                else if (!bus.mwe)
                    bus.dtr1 <= bus.mdtr;
            end

            if (grant_vld) begin
                state     <= ST_WAIT;
                owner     <= grant_port;
                cyc_cnt   <= '0;
                bus.mreq  <= 1'b1;
                bus.maddr <= req[grant_port].addr;
                bus.mdtw  <= req[grant_port].dtw;
                bus.mwe   <= req[grant_port].rw;
                if (grant_port == P_FETCH)
                    starve_cnt <= '0;
                else if (cand[P_FETCH])
                    starve_cnt <= starve_cnt + 1'b1;
            end else if (done || tmo) begin
                state    <= ST_IDLE;
                bus.mreq <= 1'b0;
            end else if (in_wait) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Directed bench for hs32_mem_arbiter: reset, priority, starvation guard,
// timeout, protocol errors and mid-access reset.
module tb_hs32_mem_arbiter;
    import hs32_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hs32_mem_arbiter_if bus();

    hs32_mem_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.addr0 = '0; bus.stb0 = 1'b0;
        bus.addr1 = '0; bus.dtw1 = '0; bus.rw1 = 1'b0; bus.stb1 = 1'b0;
        bus.mdtr  = '0; bus.mrdy = 1'b0;
    endtask

    initial begin
        int stray;
        idle_inputs();

        // 1. reset then a single fetch read
        tick(); tick();
        chk("rst_outs", {bus.ack0, bus.ack1, bus.stl0, bus.stl1, bus.mreq, bus.mwe}, 32'h0);
        chk("rst_maddr", bus.maddr, 32'h0);
        chk("rst_dtr", bus.dtr0 | bus.dtr1, 32'h0);
        reset = 1'b1;
        bus.addr0 = 32'h100; bus.stb0 = 1'b1;
        tick();
        bus.stb0 = 1'b0;
        chk("t1_mreq", bus.mreq, 1);
        chk("t1_maddr", bus.maddr, 32'h100);
        chk("t1_mwe", bus.mwe, 0);
        chk("t1_ack_early", bus.ack0, 0);
        bus.mrdy = 1'b1; bus.mdtr = 32'hDEADBEEF;
        tick();
        bus.mrdy = 1'b0;
        chk("t1_ack0", bus.ack0, 1);
        chk("t1_dtr0", bus.dtr0, 32'hDEADBEEF);
        chk("t1_mreq_lo", bus.mreq, 0);
        tick();
        chk("t1_ack_pulse", bus.ack0, 0);

        // 2. simultaneous strobes: execute write goes first, fetch back-to-back
        bus.addr0 = 32'h104; bus.stb0 = 1'b1;
        bus.addr1 = 32'h200; bus.dtw1 = 32'h55; bus.rw1 = 1'b1; bus.stb1 = 1'b1;
        tick();
        bus.stb0 = 1'b0; bus.stb1 = 1'b0;
        chk("t2_maddr1", bus.maddr, 32'h200);
        chk("t2_mwe1", bus.mwe, 1);
        chk("t2_mdtw", bus.mdtw, 32'h55);
        bus.mrdy = 1'b1; bus.mdtr = 32'h1111;
        tick();
        chk("t2_ack1", {bus.ack1, bus.ack0}, 2'b10);
        chk("t2_b2b_mreq", bus.mreq, 1);
        chk("t2_maddr0", bus.maddr, 32'h104);
        chk("t2_mwe0", bus.mwe, 0);
        chk("t2_dtr1_wr", bus.dtr1, 32'h0);
        bus.mdtr = 32'h2222;
        tick();
        bus.mrdy = 1'b0;
        chk("t2_ack0", {bus.ack1, bus.ack0}, 2'b01);
        chk("t2_dtr0", bus.dtr0, 32'h2222);
        chk("t2_mreq_lo", bus.mreq, 0);

        // 3. execute port hogs the bus while fetch waits
        bus.addr0 = 32'h400; bus.stb0 = 1'b1;
        bus.addr1 = 32'h300; bus.rw1 = 1'b0; bus.stb1 = 1'b1;
        tick();
        bus.stb0 = 1'b0;
        chk("t3_g0", bus.maddr, 32'h300);
        for (int k = 1; k <= 3; k++) begin
            bus.addr1 = 32'h300 + 32'(4 * k); bus.stb1 = 1'b1;
            bus.mrdy = 1'b1; bus.mdtr = 32'(k);
            tick();
            chk($sformatf("t3_g%0d", k), bus.maddr, 32'h300 + 32'(4 * k));
            chk($sformatf("t3_dtr1_%0d", k), bus.dtr1, 32'(k));
        end
        chk("t3_starve4", 32'(dut.starve_cnt), 32'd4);
        bus.addr1 = 32'h310; bus.stb1 = 1'b1; bus.mdtr = 32'h4;
        tick();
        bus.stb1 = 1'b0;
        chk("t3_fetch_won", bus.maddr, 32'h400);
        chk("t3_ack1", bus.ack1, 1);
        chk("t3_starve_clr", 32'(dut.starve_cnt), 32'd0);
        bus.mdtr = 32'h5;
        tick();
        chk("t3_ack0", bus.ack0, 1);
        chk("t3_next1", bus.maddr, 32'h310);
        bus.mdtr = 32'h6;
        tick();
        bus.mrdy = 1'b0;
        chk("t3_last_ack1", bus.ack1, 1);
        chk("t3_dtr1", bus.dtr1, 32'h6);
        tick();
        chk("t3_idle", bus.mreq, 0);

        // 4. timeout after 16 wait cycles, then mrdy on the 16th cycle wins
        bus.addr0 = 32'h500; bus.stb0 = 1'b1;
        tick();
        bus.stb0 = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.stl0 || !bus.mreq) stray++;
        end
        chk("t4_no_early_stl", 32'(stray), 32'd0);
        tick();
        chk("t4_stl0", {bus.stl0, bus.ack0}, 2'b10);
        chk("t4_mreq_drop", bus.mreq, 0);
        tick();
        chk("t4_stl_pulse", bus.stl0, 0);
        bus.addr0 = 32'h504; bus.stb0 = 1'b1;
        tick();
        bus.stb0 = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        bus.mrdy = 1'b1; bus.mdtr = 32'hA5A5;
        tick();
        bus.mrdy = 1'b0;
        chk("t4_late_ack", {bus.stl0, bus.ack0}, 2'b01);
        chk("t4_late_dtr0", bus.dtr0, 32'hA5A5);

        // 5. misaligned strobe and overlapping strobe
        tick();
        bus.addr1 = 32'h203; bus.rw1 = 1'b1; bus.stb1 = 1'b1;
        tick();
        bus.stb1 = 1'b0;
        chk("t5_stl1", bus.stl1, 1);
        chk("t5_no_mreq", bus.mreq, 0);
        tick();
        chk("t5_still_idle", {bus.mreq, bus.stl1}, 2'b00);
        bus.addr0 = 32'h600; bus.stb0 = 1'b1;
        tick();
        tick();
        bus.stb0 = 1'b0;
        chk("t5_stl0", {bus.stl0, bus.ack0}, 2'b10);
        chk("t5_keep_addr", bus.maddr, 32'h600);
        bus.mrdy = 1'b1; bus.mdtr = 32'h77;
        tick();
        bus.mrdy = 1'b0;
        chk("t5_orig_ack", {bus.stl0, bus.ack0}, 2'b01);
        chk("t5_dtr0", bus.dtr0, 32'h77);

        // 6. reset in WAIT abandons the access
        bus.addr0 = 32'h700; bus.stb0 = 1'b1;
        tick();
        bus.stb0 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_rst_outs", {bus.mreq, bus.ack0, bus.stl0}, 3'b000);
        chk("t6_state", 32'(dut.state), 32'(ST_IDLE));
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ack0 || bus.stl0 || bus.mreq) stray++;
        end
        chk("t6_quiet", 32'(stray), 32'd0);
        bus.addr0 = 32'h704; bus.stb0 = 1'b1;
        tick();
        bus.stb0 = 1'b0;
        chk("t6_maddr", bus.maddr, 32'h704);
        bus.mrdy = 1'b1; bus.mdtr = 32'h99;
        tick();
        bus.mrdy = 1'b0;
        chk("t6_ack0", bus.ack0, 1);
        chk("t6_dtr0", bus.dtr0, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
